// File: rtl/vt52_pkg.sv
// Shared VT52 definitions: capture FSM encoding, flow-control characters and
// default receive-buffer sizing.
package vt52_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ACK  = 2'd1,
    CAP_WAIT = 2'd2
  } cap_state_t;

  localparam logic [7:0] XON_CHAR  = 8'h11;
  localparam logic [7:0] XOFF_CHAR = 8'h13;

  localparam int VT52_DEF_DEPTH   = 16;
  localparam int VT52_DEF_HI_MARK = 12;
  localparam int VT52_DEF_LO_MARK = 4;

endpackage

// File: rtl/vt52_sync_fifo.sv
// Single-clock FIFO with occupancy count. Storage is not reset; only the
// pointers and count are.
module vt52_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted when a pop frees the slot on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vt52_rx_buffer.sv
// VT52 receive buffer: captures bytes from the UART into a FIFO, tracks
// errors/overruns and raises XON/XOFF requests around fill watermarks.
module vt52_rx_buffer
  import vt52_pkg::*;
#(
  parameter int DEPTH   = VT52_DEF_DEPTH,
  parameter int HI_MARK = VT52_DEF_HI_MARK,
  parameter int LO_MARK = VT52_DEF_LO_MARK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx_ready,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_framing_error,
  input  logic                   uart_parity_error,
  input  logic                   uart_overrun_error,
  output logic                   uart_rx_read,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_err,
  input  logic                   out_ready,
  input  logic                   flow_en,
  output logic                   send_xoff,
  output logic                   send_xon,
  output logic                   flow_stopped,
  output logic [$clog2(DEPTH):0] fill_count,
  output logic                   lost_flag,
  input  logic                   lost_clear,
  output logic [1:0]             state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  cap_state_t    state;
  cap_state_t    state_nxt;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          rx_err;
  logic [8:0]    rdata;
  logic [CW-1:0] fill_nxt;

  // Consumer handshake: the head entry transfers on every rising edge where
  // out_valid and out_ready are both high; out_ready alone has no effect.
  assign pop       = out_ready & ~empty;
  assign out_valid = ~empty;
  assign out_data  = rdata[7:0];
  assign out_err   = rdata[8];

  assign rx_err       = uart_framing_error | uart_parity_error | uart_overrun_error;
  assign uart_rx_read = (state == CAP_ACK);
  assign state_dbg    = state;
  assign fill_nxt     = fill_count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) state <= CAP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      CAP_IDLE: begin
        if (uart_rx_ready && (!full || pop)) begin
          push      = 1'b1;
          state_nxt = CAP_ACK;
        end
      end
      CAP_ACK:  state_nxt = CAP_WAIT;
      CAP_WAIT: if (!uart_rx_ready) state_nxt = CAP_IDLE;
      default:  state_nxt = CAP_IDLE;
    endcase
  end

  vt52_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({rx_err, uart_rx_data}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fill_count)
  );

  // Watermarks are judged on the post-edge fill so the pulse lines up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      send_xoff    <= 1'b0;
      send_xon     <= 1'b0;
      flow_stopped <= 1'b0;
    end else begin
      send_xoff <= 1'b0;
      send_xon  <= 1'b0;
      if (!flow_en) begin
        flow_stopped <= 1'b0;
      end else if (!flow_stopped && (fill_nxt >= CW'(HI_MARK))) begin
        send_xoff    <= 1'b1;
        flow_stopped <= 1'b1;
      end else if (flow_stopped && (fill_nxt <= CW'(LO_MARK))) begin
        send_xon     <= 1'b1;
        flow_stopped <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                           lost_flag <= 1'b0;
    else if (push && uart_overrun_error) lost_flag <= 1'b1;
    else if (lost_clear)               lost_flag <= 1'b0;
  end

endmodule

// File: tb/tb_vt52_rx_buffer.sv
// Directed bench for vt52_rx_buffer: UART-side driver tasks, an expected-entry
// queue for the consumer side and a pulse monitor for XON/XOFF.
module tb_vt52_rx_buffer;
  import vt52_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx_ready = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_framing_error = 1'b0;
  logic       uart_parity_error = 1'b0;
  logic       uart_overrun_error = 1'b0;
  logic       uart_rx_read;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_ready = 1'b0;
  logic       flow_en = 1'b0;
  logic       send_xoff;
  logic       send_xon;
  logic       flow_stopped;
  logic [4:0] fill_count;
  logic       lost_flag;
  logic       lost_clear = 1'b0;
  logic [1:0] state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [8:0] exp_q[$];

  int xoff_cnt = 0;
  int xon_cnt = 0;
  int both_cnt = 0;
  int xoff_fill = -1;
  int xon_fill = -1;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  vt52_rx_buffer dut (
    .clk                (clk),
    .rst                (rst),
    .uart_rx_ready      (uart_rx_ready),
    .uart_rx_data       (uart_rx_data),
    .uart_framing_error (uart_framing_error),
    .uart_parity_error  (uart_parity_error),
    .uart_overrun_error (uart_overrun_error),
    .uart_rx_read       (uart_rx_read),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_err            (out_err),
    .out_ready          (out_ready),
    .flow_en            (flow_en),
    .send_xoff          (send_xoff),
    .send_xon           (send_xon),
    .flow_stopped       (flow_stopped),
    .fill_count         (fill_count),
    .lost_flag          (lost_flag),
    .lost_clear         (lost_clear),
    .state_dbg          (state_dbg)
  );

  always @(negedge clk) begin
    if (send_xoff) begin
      xoff_cnt++;
      xoff_fill = int'(fill_count);
    end
    if (send_xon) begin
      xon_cnt++;
      xon_fill = int'(fill_count);
    end
    if (send_xoff && send_xon) both_cnt++;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: UART presents a byte and withdraws it once acknowledged.
  task automatic uart_send(input logic [7:0] d, input logic fe, input logic pe, input logic oe);
    bit seen = 1'b0;
    uart_rx_data       = d;
    uart_framing_error = fe;
    uart_parity_error  = pe;
    uart_overrun_error = oe;
    uart_rx_ready      = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (uart_rx_read) seen = 1'b1;
    end
    check_vec("rx_read_seen", 32'(seen), 32'd1);
    if (seen) exp_q.push_back({fe | pe | oe, d});
    uart_rx_ready      = 1'b0;
    uart_framing_error = 1'b0;
    uart_parity_error  = 1'b0;
    uart_overrun_error = 1'b0;
    tick();
    check_vec("rx_read_one_cycle", 32'(uart_rx_read), 32'd0);
    tick();
  endtask

  // Consumer: compare the head against the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    check_vec({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check_vec({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      check_vec({tag, "_entry"}, 32'({out_err, out_data}), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int rd_cnt;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_vec("rst_fill", 32'(fill_count), 32'd0);
    check_vec("rst_valid", 32'(out_valid), 32'd0);
    check_vec("rst_rx_read", 32'(uart_rx_read), 32'd0);
    check_vec("rst_xoff", 32'(send_xoff), 32'd0);
    check_vec("rst_xon", 32'(send_xon), 32'd0);
    check_vec("rst_stopped", 32'(flow_stopped), 32'd0);
    check_vec("rst_lost", 32'(lost_flag), 32'd0);
    check_vec("rst_state", 32'(state_dbg), 32'(CAP_IDLE));

    // Single byte: visible the cycle after the capture edge
    uart_rx_data  = 8'h41;
    uart_rx_ready = 1'b1;
    tick();
    check_vec("single_rx_read", 32'(uart_rx_read), 32'd1);
    check_vec("single_valid", 32'(out_valid), 32'd1);
    check_vec("single_data", 32'(out_data), 32'h41);
    check_vec("single_err", 32'(out_err), 32'd0);
    check_vec("single_fill", 32'(fill_count), 32'd1);
    exp_q.push_back({1'b0, 8'h41});
    uart_rx_ready = 1'b0;
    tick();
    check_vec("single_rx_read_drop", 32'(uart_rx_read), 32'd0);
    tick();
    pop_check("single_pop");
    check_vec("single_empty", 32'(out_valid), 32'd0);

    // Fill to 16 with flow control on
    flow_en = 1'b1;
    for (int i = 0; i < 16; i++) uart_send(8'(i), 1'b0, 1'b0, 1'b0);
    check_vec("fill_count16", 32'(fill_count), 32'd16);
    check_vec("fill_xoff_cnt", 32'(xoff_cnt), 32'd1);
    check_vec("fill_xoff_at", 32'(xoff_fill), 32'd12);
    check_vec("fill_stopped", 32'(flow_stopped), 32'd1);

    // 17th byte must not be acknowledged while full
    uart_rx_data  = 8'h10;
    uart_rx_ready = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (uart_rx_read) rd_cnt++;
    end
    check_vec("full_no_rx_read", 32'(rd_cnt), 32'd0);
    check_vec("full_fill", 32'(fill_count), 32'd16);
    check_vec("full_state_idle", 32'(state_dbg), 32'(CAP_IDLE));
    uart_rx_ready = 1'b0;
    tick();

    // Drain: order, XON at fill 4
    for (int i = 0; i < 16; i++) pop_check("drain");
    check_vec("drain_fill", 32'(fill_count), 32'd0);
    check_vec("drain_xon_cnt", 32'(xon_cnt), 32'd1);
    check_vec("drain_xon_at", 32'(xon_fill), 32'd4);
    check_vec("drain_stopped", 32'(flow_stopped), 32'd0);
    check_vec("drain_xoff_cnt", 32'(xoff_cnt), 32'd1);

    // Errors and overrun
    uart_send(8'h54, 1'b0, 1'b0, 1'b0);
    uart_send(8'h55, 1'b0, 1'b1, 1'b0);
    uart_send(8'h56, 1'b0, 1'b0, 1'b1);
    uart_send(8'h57, 1'b0, 1'b0, 1'b0);
    check_vec("err_lost_set", 32'(lost_flag), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("err_pop");
    check_vec("err_lost_held", 32'(lost_flag), 32'd1);
    lost_clear = 1'b1;
    tick();
    lost_clear = 1'b0;
    check_vec("err_lost_cleared", 32'(lost_flag), 32'd0);

    // Clear and new overrun on the same edge: set wins
    uart_rx_data       = 8'h58;
    uart_overrun_error = 1'b1;
    uart_rx_ready      = 1'b1;
    lost_clear         = 1'b1;
    tick();
    lost_clear = 1'b0;
    check_vec("clr_vs_ovr_lost", 32'(lost_flag), 32'd1);
    check_vec("clr_vs_ovr_rx_read", 32'(uart_rx_read), 32'd1);
    exp_q.push_back({1'b1, 8'h58});
    uart_rx_ready      = 1'b0;
    uart_overrun_error = 1'b0;
    tick();
    tick();
    pop_check("clr_vs_ovr_pop");
    lost_clear = 1'b1;
    tick();
    lost_clear = 1'b0;

    // Simultaneous push and pop at fill 1
    uart_send(8'h30, 1'b0, 1'b0, 1'b0);
    check_vec("conc1_fill_before", 32'(fill_count), 32'd1);
    uart_rx_data  = 8'h31;
    uart_rx_ready = 1'b1;
    out_ready     = 1'b1;
    check_vec("conc1_head", 32'({out_err, out_data}), 32'(exp_q[0]));
    tick();
    void'(exp_q.pop_front());
    exp_q.push_back({1'b0, 8'h31});
    out_ready = 1'b0;
    check_vec("conc1_fill", 32'(fill_count), 32'd1);
    check_vec("conc1_rx_read", 32'(uart_rx_read), 32'd1);
    check_vec("conc1_data", 32'(out_data), 32'h31);
    uart_rx_ready = 1'b0;
    tick();
    tick();

    // Refill to 16, then disable flow control: cleared without XON
    for (int i = 0; i < 15; i++) uart_send(8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    check_vec("refill_fill", 32'(fill_count), 32'd16);
    check_vec("refill_xoff_cnt", 32'(xoff_cnt), 32'd2);
    check_vec("refill_stopped", 32'(flow_stopped), 32'd1);
    flow_en = 1'b0;
    tick();
    check_vec("flow_dis_stopped", 32'(flow_stopped), 32'd0);
    check_vec("flow_dis_xon_cnt", 32'(xon_cnt), 32'd1);

    // Simultaneous push and pop at fill 16
    uart_rx_data  = 8'hC0;
    uart_rx_ready = 1'b1;
    out_ready     = 1'b1;
    check_vec("conc16_head", 32'({out_err, out_data}), 32'(exp_q[0]));
    tick();
    void'(exp_q.pop_front());
    exp_q.push_back({1'b0, 8'hC0});
    out_ready = 1'b0;
    check_vec("conc16_fill", 32'(fill_count), 32'd16);
    check_vec("conc16_rx_read", 32'(uart_rx_read), 32'd1);
    uart_rx_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) pop_check("wrap_drain");
    check_vec("wrap_fill", 32'(fill_count), 32'd0);
    check_vec("wrap_xon_cnt", 32'(xon_cnt), 32'd1);
    check_vec("wrap_xoff_cnt", 32'(xoff_cnt), 32'd2);
    check_vec("both_pulses", 32'(both_cnt), 32'd0);

    // Reset during ACK with 5 entries; held byte captured afterwards
    flow_en = 1'b1;
    for (int i = 0; i < 4; i++) uart_send(8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    uart_rx_data  = 8'h77;
    uart_rx_ready = 1'b1;
    tick();
    check_vec("mid_ack_state", 32'(state_dbg), 32'(CAP_ACK));
    check_vec("mid_ack_fill", 32'(fill_count), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_vec("mid_rst_fill", 32'(fill_count), 32'd0);
    check_vec("mid_rst_valid", 32'(out_valid), 32'd0);
    check_vec("mid_rst_rx_read", 32'(uart_rx_read), 32'd0);
    tick();
    check_vec("post_rst_rx_read", 32'(uart_rx_read), 32'd1);
    check_vec("post_rst_fill", 32'(fill_count), 32'd1);
    exp_q.push_back({1'b0, 8'h77});
    uart_rx_ready = 1'b0;
    tick();
    tick();
    pop_check("post_rst_pop");
    check_vec("post_rst_empty", 32'(fill_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
